// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive / transmit datapath.
// Channel count, word and index widths, and the arbiter FSM encoding.
package i2s_pkg;

    localparam int I2S_CH_NUM = 16;
    localparam int I2S_DATA_W = 32;
    localparam int I2S_IDX_W  = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first requester strictly after
// last_grant, searching upward and wrapping modulo N.
module rr_priority_pick
    import i2s_pkg::*;
#(
    parameter int N     = I2S_CH_NUM,
    parameter int IDX_W = I2S_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan from farthest to nearest so the nearest requester is assigned last and wins.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = N; k >= 1; k--) begin
            pos     = (int'(last_grant) + k) % N;
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_arbiter.sv
// Frame-granular round-robin merge of the per-channel I2S receive streams into one
// tagged AXI-Stream, with a beat-count guard that force-terminates runaway frames.
module i2s_rx_arbiter
    import i2s_pkg::*;
#(
    parameter int CH_NUM    = I2S_CH_NUM,
    parameter int DATA_W    = I2S_DATA_W,
    parameter int MAX_BEATS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        s_axis_tvalid,
    output logic [CH_NUM-1:0]        s_axis_tready,
    input  logic [CH_NUM*DATA_W-1:0] s_axis_tdata,
    input  logic [CH_NUM-1:0]        s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [3:0]               m_axis_tid,
    output logic [3:0]               m_axis_tdest,
    input  logic [CH_NUM-1:0]        i_enable,
    input  logic [4*CH_NUM-1:0]      i_dst_fpga_index,
    output logic [15:0]              o_overrun_count
);

    localparam int                     CNT_W     = 9;
    localparam logic [CNT_W-1:0]       LAST_BEAT = CNT_W'(MAX_BEATS - 1);
    localparam logic [I2S_IDX_W-1:0]   LAST_CH   = I2S_IDX_W'(CH_NUM - 1);

    logic [0:0]           state_q, state_d;
    logic [I2S_IDX_W-1:0] grant_q, grant_d;
    logic [I2S_IDX_W-1:0] last_grant_q, last_grant_d;
    logic [3:0]           tdest_q, tdest_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [DATA_W-1:0]    m_data_q, m_data_d;
    logic                 m_last_q, m_last_d;
    logic [3:0]           m_tid_q, m_tid_d;
    logic [3:0]           m_tdest_q, m_tdest_d;
    logic [15:0]          overrun_q, overrun_d;

    logic [CH_NUM-1:0]    cand;
    logic                 pick_found;
    logic [I2S_IDX_W-1:0] pick_idx;
    logic                 src_ready;
    logic                 accept;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_last;
    logic                 beat_last;

    rr_priority_pick #(
        .N     (CH_NUM),
        .IDX_W (I2S_IDX_W)
    ) u_pick (
        .req        (cand),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // Ready is masked during reset so a source never sees a handshake that gets discarded.
    always_comb begin
        cand      = i_enable & s_axis_tvalid;
        src_ready = (state_q == ST_BURST) && (!m_valid_q || m_axis_tready) && !rst;
        accept    = src_ready && s_axis_tvalid[grant_q];
        sel_data  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
        sel_last  = s_axis_tlast[grant_q];
        beat_last = sel_last || (beat_cnt_q == LAST_BEAT);
        s_axis_tready           = '0;
        s_axis_tready[grant_q]  = src_ready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tdest_d      = tdest_q;
        beat_cnt_d   = beat_cnt_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        m_tid_d      = m_tid_q;
        m_tdest_d    = m_tdest_q;
        overrun_d    = overrun_q;

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                grant_d    = pick_idx;
                tdest_d    = i_dst_fpga_index[int'(pick_idx)*4 +: 4];
                beat_cnt_d = '0;
                state_d    = ST_BURST;
            end
        end else if (accept) begin
            m_valid_d  = 1'b1;
            m_data_d   = sel_data;
            m_last_d   = beat_last;
            m_tid_d    = grant_q;
            m_tdest_d  = tdest_q;
            beat_cnt_d = beat_cnt_q + 1'b1;
            // A guard-forced end leaves the tail of the source frame for the next grant.
            if (beat_last) begin
                state_d      = ST_IDLE;
                last_grant_d = grant_q;
                if (!sel_last && overrun_q != 16'hFFFF) begin
                    overrun_d = overrun_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
            tdest_q      <= '0;
            beat_cnt_q   <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_tid_q      <= '0;
            m_tdest_q    <= '0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tdest_q      <= tdest_d;
            beat_cnt_q   <= beat_cnt_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_tid_q      <= m_tid_d;
            m_tdest_q    <= m_tdest_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_axis_tvalid   = m_valid_q;
    assign m_axis_tdata    = m_data_q;
    assign m_axis_tlast    = m_last_q;
    assign m_axis_tid      = m_tid_q;
    assign m_axis_tdest    = m_tdest_q;
    assign o_overrun_count = overrun_q;

endmodule

// File: tb/tb_i2s_rx_arbiter.sv
// Bench for i2s_rx_arbiter: per-channel source queues feed the DUT while a frame-level
// round-robin model predicts the merged output stream, tags and overrun count.
module tb_i2s_rx_arbiter;

    localparam int CH   = 16;
    localparam int DW   = 32;
    localparam int MAXB = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } src_beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  tid;
        logic [3:0]  tdest;
    } out_beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   s_valid;
    logic [CH-1:0]   s_ready;
    logic [CH*DW-1:0] s_data;
    logic [CH-1:0]   s_last;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [3:0]      m_tid;
    logic [3:0]      m_tdest;
    logic [CH-1:0]   en;
    logic [4*CH-1:0] dst_flat;
    logic [15:0]     overrun;

    src_beat_t src_q[CH][$];
    src_beat_t mdl_q[CH][$];
    out_beat_t exp_q[$];
    logic [3:0] dst[CH];

    int mdl_last;
    int exp_overrun;
    int checks   = 0;
    int failures = 0;
    int first_valid_cyc, first_hs_cyc, last_hs_cyc, hs_count, first_tid;

    always #5 clk = ~clk;

    always_comb begin
        dst_flat = '0;
        for (int i = 0; i < CH; i++) dst_flat[4*i +: 4] = dst[i];
    end

    i2s_rx_arbiter #(
        .CH_NUM    (CH),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tvalid    (s_valid),
        .s_axis_tready    (s_ready),
        .s_axis_tdata     (s_data),
        .s_axis_tlast     (s_last),
        .m_axis_tvalid    (m_valid),
        .m_axis_tready    (m_ready),
        .m_axis_tdata     (m_data),
        .m_axis_tlast     (m_last),
        .m_axis_tid       (m_tid),
        .m_axis_tdest     (m_tdest),
        .i_enable         (en),
        .i_dst_fpga_index (dst_flat),
        .o_overrun_count  (overrun)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tvalid"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_tdata"}, 64'(m_data), 64'd0);
        checkOutput({tag, "_tlast"}, 64'(m_last), 64'd0);
        checkOutput({tag, "_tid"}, 64'(m_tid), 64'd0);
        checkOutput({tag, "_tdest"}, 64'(m_tdest), 64'd0);
        checkOutput({tag, "_s_tready"}, 64'(s_ready), 64'd0);
        checkOutput({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    task automatic driveSources();
        for (int i = 0; i < CH; i++) begin
            if (src_q[i].size() > 0) begin
                s_valid[i]        = 1'b1;
                s_data[DW*i +: DW] = src_q[i][0].data;
                s_last[i]         = src_q[i][0].last;
            end else begin
                s_valid[i]        = 1'b0;
                s_data[DW*i +: DW] = '0;
                s_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic loadFrame(input int ch, input int len, input bit has_last);
        src_beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.last = has_last && (i == len - 1);
            src_q[ch].push_back(b);
            mdl_q[ch].push_back(b);
        end
    endtask

    task automatic clearQueues();
        for (int i = 0; i < CH; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
    endtask

    // Frame-level reference: whole frames in round-robin order, split every MAXB beats.
    task automatic modelFrames(input logic [CH-1:0] en_mask, input int max_frames);
        int frames, pick, n, c;
        bit done;
        src_beat_t b;
        out_beat_t o;
        frames = 0;
        while (max_frames < 0 || frames < max_frames) begin
            pick = -1;
            for (int k = 1; k <= CH; k++) begin
                c = (mdl_last + k) % CH;
                if (pick < 0 && en_mask[c] && mdl_q[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            n    = 0;
            done = 1'b0;
            while (!done && mdl_q[pick].size() > 0) begin
                b = mdl_q[pick].pop_front();
                n++;
                o.data  = b.data;
                o.tid   = 4'(pick);
                o.tdest = dst[pick];
                o.last  = b.last || (n == MAXB);
                if (!b.last && n == MAXB) exp_overrun++;
                exp_q.push_back(o);
                done = o.last;
            end
            mdl_last = pick;
            frames++;
        end
    endtask

    task automatic popHandshakes(input int hook_ch, output int hooked);
        hooked = 0;
        for (int i = 0; i < CH; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                void'(src_q[i].pop_front());
                if (i == hook_ch) hooked++;
            end
        end
    endtask

    task automatic doReset(input string tag);
        rst     = 1'b1;
        en      = '0;
        m_ready = 1'b0;
        clearQueues();
        driveSources();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checkResetValues(tag);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mdl_last    = CH - 1;
        exp_overrun = 0;
    endtask

    // Runs sources and sink until the expected stream drains; entered and left at posedge+1.
    task automatic applyStimulus(input int ready_mode, input int max_cycles, input int hook_ch, input int hook_beats);
        int cyc, idle, hook_cnt, hooked, exp_total;
        bit prev_stall, stop;
        logic [41:0] snap, cur;
        out_beat_t e;
        first_valid_cyc = -1;
        first_hs_cyc    = -1;
        last_hs_cyc     = -1;
        first_tid       = -1;
        hs_count        = 0;
        cyc = 0; idle = 0; hook_cnt = 0;
        prev_stall = 1'b0; stop = 1'b0; snap = '0;
        exp_total  = exp_q.size();
        while (!stop) begin
            driveSources();
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
            @(negedge clk);
            cur = {m_valid, m_data, m_last, m_tid, m_tdest};
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            checkOutput("ready_onehot", 64'($onehot0(s_ready)), 64'd1);
            if (m_valid && !m_ready) checkOutput("ready_when_full", 64'(s_ready), 64'd0);
            if (prev_stall) checkOutput("hold_stable", 64'(cur), 64'(snap));
            popHandshakes(hook_ch, hooked);
            hook_cnt += hooked;
            if (m_valid && m_ready) begin
                if (first_hs_cyc < 0) begin
                    first_hs_cyc = cyc;
                    first_tid    = int'(m_tid);
                end
                last_hs_cyc = cyc;
                hs_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("extra_beat", 64'(hs_count), 64'(exp_total));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_beat", 64'({m_data, m_last, m_tid, m_tdest}), 64'(e));
                end
            end
            prev_stall = m_valid && !m_ready;
            snap       = cur;
            if (exp_q.size() == 0) idle++;
            if (idle >= 6) begin
                stop = 1'b1;
            end else if (cyc >= max_cycles) begin
                checkOutput("timeout_pending", 64'(exp_q.size()), 64'd0);
                stop = 1'b1;
            end
            cyc++;
            @(posedge clk);
            #1;
            if (hook_ch >= 0 && hook_cnt >= hook_beats) en[hook_ch] = 1'b0;
        end
    endtask

    initial begin
        int cnt, hooked;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        for (int i = 0; i < CH; i++) dst[i] = 4'($urandom);

        $display("[TB] reset values");
        doReset("por");

        $display("[TB] single channel 3, 8-beat frame");
        en = 16'h0008;
        loadFrame(3, 8, 1'b1);
        modelFrames(en, -1);
        applyStimulus(0, 200, -1, 0);
        checkOutput("ch3_latency", 64'(first_valid_cyc), 64'd2);
        checkOutput("ch3_beats", 64'(hs_count), 64'd8);

        $display("[TB] channels 0,5,9 round robin");
        doReset("rst_b");
        en = 16'h0221;
        for (int f = 0; f < 2; f++) begin
            loadFrame(0, 4, 1'b1);
            loadFrame(5, 4, 1'b1);
            loadFrame(9, 4, 1'b1);
        end
        modelFrames(en, -1);
        applyStimulus(0, 300, -1, 0);
        checkOutput("rr_first_tid", 64'(first_tid), 64'd0);
        checkOutput("rr_span_one_bubble", 64'(last_hs_cyc - first_hs_cyc), 64'd28);

        $display("[TB] toggling sink ready, 16-beat frame");
        en = 16'h1000;
        loadFrame(12, 16, 1'b1);
        modelFrames(en, -1);
        applyStimulus(1, 300, -1, 0);
        checkOutput("toggle_beats", 64'(hs_count), 64'd16);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 4; r++) begin
            en = 16'h8001 | (16'($urandom) & 16'($urandom));
            for (int i = 0; i < CH; i++) begin
                dst[i] = 4'($urandom);
                if (en[i]) begin
                    for (int f = 0; f < int'($urandom_range(1, 3)); f++)
                        loadFrame(i, int'($urandom_range(1, 6)), 1'b1);
                end else if ($urandom_range(0, 3) == 0) begin
                    loadFrame(i, 3, 1'b1);
                end
            end
            modelFrames(en, -1);
            applyStimulus(2, 3000, -1, 0);
            clearQueues();
            driveSources();
        end

        $display("[TB] frame-length guard on channel 1");
        en = 16'h0002;
        loadFrame(1, 40, 1'b1);
        modelFrames(en, -1);
        applyStimulus(0, 300, -1, 0);
        checkOutput("guard_beats", 64'(hs_count), 64'd40);
        checkOutput("overrun_count", 64'(overrun), 64'(exp_overrun));

        $display("[TB] enable dropped mid-frame on channel 5");
        doReset("rst_d");
        en = 16'h0120;
        loadFrame(5, 6, 1'b1);
        loadFrame(5, 3, 1'b1);
        loadFrame(8, 3, 1'b1);
        loadFrame(8, 3, 1'b1);
        modelFrames(en, 1);
        modelFrames(16'h0100, -1);
        applyStimulus(0, 300, 5, 2);
        checkOutput("ch5_not_regranted", 64'(src_q[5].size()), 64'd3);
        clearQueues();
        driveSources();

        $display("[TB] reset in the middle of a frame");
        en = 16'h0004;
        loadFrame(2, 10, 1'b1);
        m_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30 && cnt < 3; c++) begin
            driveSources();
            @(negedge clk);
            popHandshakes(-1, hooked);
            if (m_valid && m_ready) cnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("beats_before_reset", 64'(cnt), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearQueues();
        exp_q.delete();
        mdl_last    = CH - 1;
        exp_overrun = 0;
        en = 16'h0081;
        loadFrame(0, 2, 1'b1);
        loadFrame(7, 2, 1'b1);
        modelFrames(en, -1);
        applyStimulus(0, 200, -1, 0);
        checkOutput("first_grant_after_reset", 64'(first_tid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
